// File: rtl/if_stage.sv
// Minos RV32I fetch stage: credit-limited in-order fetch with a small queue.
// Define IF_PERF_CNT_EN to add the FetchCnt/FlushCnt performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        rst,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    input  logic        DEStall,
    input  logic        DEBranchFlush,
    input  logic [31:0] BJumpRSIMM,
    output logic [31:0] IFPC,
    output logic [31:0] INS,
    output logic        IFValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] FetchCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam int IW = $clog2(FQ_DEPTH);
    localparam int PW = IW + 1;
    localparam int DW = PW + 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [DW-1:0] drop_t;

    localparam ptr_t  P_ONE = ptr_t'(1);
    localparam ptr_t  P_CAP = ptr_t'(FQ_DEPTH);
    localparam drop_t D_ONE = drop_t'(1);

    // One ring holds pending PCs and queued words: head..fill is the
    // fetch queue, fill..tail the requests still out at memory.
    logic [31:0] r_pc  [FQ_DEPTH];
    logic [31:0] r_ins [FQ_DEPTH];

    logic [31:0] r_fpc;
    ptr_t        r_head;
    ptr_t        r_fill;
    ptr_t        r_tail;
    drop_t       r_drop;

    ptr_t        w_qcnt;
    ptr_t        w_outst;
    ptr_t        w_used;
    logic        w_pop;
    logic        w_credit;
    logic        w_grant;
    logic        w_drop_nz;
    logic        w_live;
    logic        w_stale_rsp;
    drop_t       w_drop_flush;
    logic [IW-1:0] w_hidx;
    logic [IW-1:0] w_fidx;
    logic [IW-1:0] w_tidx;

    assign w_qcnt  = r_fill - r_head;
    assign w_outst = r_tail - r_fill;
    assign w_used  = r_tail - r_head;
    assign w_hidx  = r_head[IW-1:0];
    assign w_fidx  = r_fill[IW-1:0];
    assign w_tidx  = r_tail[IW-1:0];

    assign IFValid = (w_qcnt != '0);
    assign w_pop   = IFValid && !DEStall;

    // A slot freed by this cycle's pop is reusable at once, giving one
    // instruction per cycle with a single-cycle memory.
    assign w_credit = (w_used - ptr_t'(w_pop)) < P_CAP;
    assign IMemReq  = !rst && w_credit && !DEBranchFlush;
    assign IMemAddr = r_fpc;
    assign w_grant  = IMemReq && IMemGnt;

    assign w_drop_nz   = (r_drop != '0);
    assign w_live      = IMemRValid && !w_drop_nz && (w_outst != '0);
    assign w_stale_rsp = IMemRValid && (w_drop_nz || (w_outst != '0));

    assign w_drop_flush = r_drop + drop_t'(w_outst) + drop_t'(w_grant)
                        - drop_t'(w_stale_rsp);

    assign IFPC = IFValid ? r_pc[w_hidx]  : r_fpc;
    assign INS  = IFValid ? r_ins[w_hidx] : NOP;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_fpc  <= RESET_PC;
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
            r_drop <= '0;
        end else if (DEBranchFlush) begin
            r_fpc  <= {BJumpRSIMM[31:2], 2'b00};
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
            r_drop <= w_drop_flush;
        end else begin
            if (w_grant) begin
                r_fpc  <= r_fpc + 32'd4;
                r_tail <= r_tail + P_ONE;
            end
            if (w_live) begin
                r_fill <= r_fill + P_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + P_ONE;
            end
            if (IMemRValid && w_drop_nz) begin
                r_drop <= r_drop - D_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_grant) begin
            r_pc[w_tidx] <= r_fpc;
        end
        if (w_live && !DEBranchFlush) begin
            r_ins[w_fidx] <= IMemRData;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (DEBranchFlush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign FetchCnt = r_fetch_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the Minos RV32I pipeline. It owns the fetch PC, issues in-order requests to instruction memory, and buffers returned words in a small fetch queue. It presents `IFPC`/`INS` to the decode stage and consumes the decode stage's branch redirect (`DEBranchFlush`, `BJumpRSIMM`) and stall (`DEStall`). It is the producer end of the IF→DE interface.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `FQ_DEPTH`, default 2: fetch-queue entries, power of two ≥ 2; also the cap on outstanding plus queued fetches.

- `CLK`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IMemReq`  out  1  fetch request valid.
- `IMemAddr`  out  32  fetch address, word aligned.
- `IMemGnt`  in  1  memory accepts the request this cycle.
- `IMemRValid`  in  1  read data valid; responses arrive in order, ≥1 cycle after grant.
- `IMemRData`  in  32  instruction word.
- `DEStall`  in  1  decode not accepting this cycle.
- `DEBranchFlush`  in  1  redirect fetch; has priority over all other events.
- `BJumpRSIMM`  in  32  redirect target.
- `IFPC`  out  32  PC of the presented instruction.
- `INS`  out  32  presented instruction; 32'h0000_0013 (NOP) when invalid.
- `IFValid`  out  1  `IFPC`/`INS` are valid.

## Operation
- State:
  - `FPC`: next fetch PC.
  - `outst`: count of granted requests not yet returned, 0..FQ_DEPTH.
  - Pending-PC FIFO: PCs of outstanding requests.
  - Fetch queue: {PC, word} pairs.
  - `drop`: count of stale responses to discard.
- Credit rule: `IMemReq = !rst && (outst + qcount + drop < FQ_DEPTH ... counted over live entries only) && !DEBranchFlush`. Concretely, live `outst` + `qcount` must be < FQ_DEPTH. `IMemAddr = FPC`.
  - Memory samples the address only when `IMemReq && IMemGnt`.
  - The address may change while ungranted, but only on a flush.
- Grant:
  - `FPC <= FPC + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Push `FPC` onto the pending-PC FIFO.
- Response:
  - If `drop > 0`, decrement `drop` and discard the word.
  - Otherwise pop the pending PC and push {PC, `IMemRData`} into the queue.
- Presentation: the queue head drives `IFPC`/`INS`; `IFValid` is asserted when the queue is non-empty.
- Pop: the head is popped when `IFValid && !DEStall`. Push and pop may occur in the same cycle. Overflow is impossible because slots are reserved at grant.
- Flush (`DEBranchFlush=1` in cycle t):
  - `FPC <= {BJumpRSIMM[31:2],2'b00}`.
  - Clear the fetch queue and the pending-PC FIFO.
  - `drop <= drop + outst`, including any grant and excluding any response that occurs in cycle t; both of those are stale.
  - `outst <= 0`.
  - A stall in cycle t is ignored.
- Reset: all counts, FIFOs and `drop` are cleared; `FPC <= RESET_PC`.

## Timing
- Reset values of outputs: `IMemReq=0`, `IMemAddr=RESET_PC`, `IFValid=0`, `IFPC=RESET_PC`, `INS=32'h0000_0013`.
- First request: `IMemReq=1` in the first cycle with `rst=0`.
- Latency: grant at t, `IMemRValid` at t+k gives `IFValid` at t+k+1. With k=1 and a continuous grant, throughput is one instruction per cycle.
- After a flush at t:
  - At t+1: `IFValid=0`, `IMemReq=1`, `IMemAddr` = aligned target.
  - The first valid redirected instruction appears no earlier than t+3.
- Stall: `IFPC`/`INS`/`IFValid` hold stable while `DEStall=1` and no flush occurs. Fetch continues until credits are exhausted.
- `rst` asserted mid-operation: outputs take reset values the next cycle. Responses arriving after reset for pre-reset requests are not tracked; the memory is reset together with this block.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds output `FetchCnt` (32), which increments on each pop.
  - Adds output `FlushCnt` (32), which increments on each cycle with `DEBranchFlush=1`.
  - Both counters are 0 on reset and wrap at 2^32.
- `IF_PERF_CNT_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `rst=1` for 3 cycles → `IMemReq=0`, `IFValid=0`, `INS=0x13`, `IFPC=0`. In the first cycle after release, `IMemReq=1` and `IMemAddr=0`.
- Streaming: 1-cycle memory, `IMemGnt=1`, `DEStall=0`, mem[n]=0x1000+n → `IFPC`=0,4,8,… with matching `INS`, one per cycle from cycle 3.
- Backpressure: `FQ_DEPTH=2`, `DEStall=1` for 6 cycles → at most 2 grants and `IFPC`/`INS` stable. On release, the next addresses are delivered in order with no gaps or duplicates.
- Flush: `BJumpRSIMM=0x103` with 2 outstanding → next cycle `IFValid=0` and `IMemAddr=0x100`. Both stale responses are discarded; the first valid `IFPC=0x100`.
- Corner: flush coincident with a grant, a response, and a `DEStall=1` → all three old words are dropped and `FPC=target`. Wrap case: `RESET_PC=0xFFFF_FFFC` gives second fetch address 0.
- With `IF_PERF_CNT_EN`: 10 pops and 2 flushes → `FetchCnt=10`, `FlushCnt=2`.
